median_frame_ctrl: RTL and testbench



---
 rtl/vip_ctrl_pkg.sv | 41 ++++
 rtl/median_frame_ctrl_if.sv | 34 +++
 rtl/vip_sync_edge.sv | 25 ++
 rtl/median_frame_ctrl.sv | 161 ++++++++++++++++
 tb/tb_median_frame_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vip_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// vip_ctrl_pkg
// Shared definitions for the image-pipeline frame controllers.
//   state_t       : frame FSM states (IDLE / WAIT_SOF / ACTIVE / DONE)
//   SEL_*         : per-pixel output select codes driven on ctrl_sel
//   BMODE_*       : cfg_border_mode codes
//   sat_inc10     : 10-bit increment that saturates at 1023
//   sel_for       : maps shadow config + border flag to an output select
// ---------------------------------------------------------------------------
package vip_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [1:0] SEL_MEDIAN = 2'd0;
  localparam logic [1:0] SEL_RAW    = 2'd1;
  localparam logic [1:0] SEL_ZERO   = 2'd2;

  localparam logic [1:0] BMODE_FILT     = 2'd0;
  localparam logic [1:0] BMODE_RAW      = 2'd1;
  localparam logic [1:0] BMODE_ZERO     = 2'd2;
  localparam logic [1:0] BMODE_FILT_ALT = 2'd3;  // behaves like BMODE_FILT

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [1:0] sel_for(input logic       filter_en,
                                         input logic [1:0] mode,
                                         input logic       border);
    if (!filter_en)                      return SEL_RAW;
    else if (border && mode == BMODE_RAW)  return SEL_RAW;
    else if (border && mode == BMODE_ZERO) return SEL_ZERO;
    else                                   return SEL_MEDIAN;
  endfunction

endpackage

// File: rtl/median_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// median_frame_ctrl_if
// Bundles the filter post-side timing inputs and the per-pixel control
// outputs of median_frame_ctrl.
//   per_frame_vsync : high for the whole frame
//   per_frame_href  : high during an active line
//   per_frame_clken : pixel strobe (a pixel is href & clken)
//   ctrl_valid      : one cycle after each accepted pixel
//   ctrl_sel        : 0 median, 1 raw, 2 zero (qualified by ctrl_valid)
//   ctrl_border     : pixel is on the first/last row or column
// Handshake: there is no back-pressure. A pixel is transferred in every
// cycle where href & clken is high; a control word is transferred in every
// cycle where ctrl_valid is high, and ctrl_sel/ctrl_border are meaningful
// only in those cycles.
// Modports: master = video source / control consumer, slave = controller.
// ---------------------------------------------------------------------------
interface median_frame_ctrl_if;
  logic       per_frame_vsync;
  logic       per_frame_href;
  logic       per_frame_clken;
  logic       ctrl_valid;
  logic [1:0] ctrl_sel;
  logic       ctrl_border;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken,
    input  ctrl_valid, ctrl_sel, ctrl_border
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken,
    output ctrl_valid, ctrl_sel, ctrl_border
  );
endinterface

// File: rtl/vip_sync_edge.sv
// ---------------------------------------------------------------------------
// vip_sync_edge
// Registers a 1-bit timing signal and reports its edges.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : signal to watch
//   rise       : d & ~d_q (combinational, same cycle as the new level)
//   fall       : ~d & d_q
// ---------------------------------------------------------------------------
module vip_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;
endmodule

// File: rtl/median_frame_ctrl.sv
// ---------------------------------------------------------------------------
// median_frame_ctrl
// Frame-level controller for the 3x3 grey median stage. Tracks pixel column
// (x) and row (y) from the post-side timing signals, latches per-frame
// configuration at start of frame, emits a per-pixel output select, and
// flags frames whose geometry differs from IMG_HDISP x IMG_VDISP.
// Build option: MEDIAN_CTRL_STATS_EN builds the completed-frame counter;
// without it frame_cnt is tied to 0.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   vid              : timing inputs / control outputs (slave modport)
//   cfg_filter_en    : median enable, sampled at start of frame
//   cfg_border_mode  : border handling, sampled at start of frame
//   err_clr          : clears the sticky error flags (wins over a set)
//   frame_active     : controller is in ACTIVE
//   frame_done       : one-cycle pulse per completed frame
//   line_err         : sticky, a line length differed from IMG_HDISP
//   size_err         : sticky, a frame line count differed from IMG_VDISP
//   frame_cnt        : completed frames, wraps
//   dbg_state        : current FSM state
// ---------------------------------------------------------------------------
module median_frame_ctrl
  import vip_ctrl_pkg::*;
#(
  parameter logic [9:0] IMG_HDISP = 10'd640,
  parameter logic [9:0] IMG_VDISP = 10'd480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  median_frame_ctrl_if.slave   vid,
  input  logic                 cfg_filter_en,
  input  logic [1:0]           cfg_border_mode,
  input  logic                 err_clr,
  output logic                 frame_active,
  output logic                 frame_done,
  output logic                 line_err,
  output logic                 size_err,
  output logic [15:0]          frame_cnt,
  output state_t               dbg_state
);

  state_t     state, state_n;
  logic       vs_rise, vs_fall, hs_rise, hs_fall;
  logic [9:0] x, y;
  logic       sh_filter_en;
  logic [1:0] sh_border_mode;

  logic       pix, sof, eol, sol, chk_frame, border;
  logic [1:0] sel_d;

  vip_sync_edge u_vs_edge (
    .clk (clk), .rst_n (rst_n), .d (vid.per_frame_vsync),
    .rise(vs_rise), .fall(vs_fall)
  );

  vip_sync_edge u_hs_edge (
    .clk (clk), .rst_n (rst_n), .d (vid.per_frame_href),
    .rise(hs_rise), .fall(hs_fall)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state. IDLE waits for vsync low so a frame already running at
  // reset release is skipped; a vsync rise during DONE is deliberately lost.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (!vid.per_frame_vsync) state_n = WAIT_SOF;
      WAIT_SOF: if (vs_rise)              state_n = ACTIVE;
      ACTIVE:   if (vs_fall)              state_n = DONE;
      DONE:                               state_n = WAIT_SOF;
      default:                            state_n = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    pix       = (state == ACTIVE) & vid.per_frame_href & vid.per_frame_clken;
    sof       = (state == WAIT_SOF) & vs_rise;
    eol       = (state == ACTIVE) & hs_fall;
    sol       = (state == ACTIVE) & hs_rise;
    chk_frame = (state == DONE);
    // Border uses the current (pre-increment) column of this pixel.
    border    = (x == 10'd0) | (x == IMG_HDISP - 10'd1) |
                (y == 10'd0) | (y == IMG_VDISP - 10'd1);
    sel_d     = sel_for(sh_filter_en, sh_border_mode, border);
  end

  // Position counters and shadow configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x              <= '0;
      y              <= '0;
      sh_filter_en   <= 1'b0;
      sh_border_mode <= '0;
    end else if (sof) begin
      x              <= '0;
      y              <= '0;
      sh_filter_en   <= cfg_filter_en;
      sh_border_mode <= cfg_border_mode;
    end else if (eol) begin
      x <= '0;
      y <= sat_inc10(y);
    end else if (sol) begin
      // x is already zero here; re-zeroing at line start keeps a pixel in
      // the href-rise cycle counted as column 0.
      x <= {9'd0, pix};
    end else if (pix) begin
      x <= sat_inc10(x);
    end
  end

  // Sticky errors. The frame check runs in DONE so a line update in the
  // vsync-fall cycle is already reflected in y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_err <= 1'b0;
      size_err <= 1'b0;
    end else begin
      if (err_clr)                         line_err <= 1'b0;
      else if (eol && (x != IMG_HDISP))    line_err <= 1'b1;
      if (err_clr)                         size_err <= 1'b0;
      else if (chk_frame && (y != IMG_VDISP)) size_err <= 1'b1;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid.ctrl_valid  <= 1'b0;
      vid.ctrl_sel    <= SEL_MEDIAN;
      vid.ctrl_border <= 1'b0;
      frame_active    <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      vid.ctrl_valid <= pix;
      if (pix) begin
        vid.ctrl_sel    <= sel_d;
        vid.ctrl_border <= border;
      end
      frame_active <= (state_n == ACTIVE);
      frame_done   <= (state_n == DONE);
    end
  end

`ifdef MEDIAN_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 frame_cnt <= '0;
    else if (state_n == DONE)   frame_cnt <= frame_cnt + 16'd1;
  end
`else
  assign frame_cnt = 16'd0;
`endif

  assign dbg_state = state;

endmodule

// File: tb/tb_median_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_median_frame_ctrl
// Drives frames into a 4x3-configured median_frame_ctrl. Expected control
// words are pushed as pixels are driven; a negedge monitor pops and compares
// whenever ctrl_valid is high. Frame status is compared after each frame.
// ---------------------------------------------------------------------------
module tb_median_frame_ctrl;
  import vip_ctrl_pkg::*;

  localparam int H = 4;
  localparam int V = 3;

  logic        clk;
  logic        rst_n;
  logic        cfg_filter_en;
  logic [1:0]  cfg_border_mode;
  logic        err_clr;
  logic        frame_active, frame_done, line_err, size_err;
  logic [15:0] frame_cnt;
  state_t      dbg_state;

  median_frame_ctrl_if vid ();

  median_frame_ctrl #(.IMG_HDISP(10'd4), .IMG_VDISP(10'd3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vid            (vid.slave),
    .cfg_filter_en  (cfg_filter_en),
    .cfg_border_mode(cfg_border_mode),
    .err_clr        (err_clr),
    .frame_active   (frame_active),
    .frame_done     (frame_done),
    .line_err       (line_err),
    .size_err       (size_err),
    .frame_cnt      (frame_cnt),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [2:0] exp_q[$];     // {sel[1:0], border}
  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;

  // Reference model state
  bit   sh_en;
  logic [1:0] sh_mode;
  bit   exp_line_err, exp_size_err;
  int   exp_frames;      // completed frames since last reset
  int   done_base;       // done_cnt value at last reset
  int   line_len[8];
  int   n_lines;
  bit   coincide;
  bit   cfg_toggle;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (frame_done) begin
      done_cnt++;
      chk("frame_done_single_cycle", int'(prev_done), 0);
    end
    prev_done = frame_done;
    if (vid.ctrl_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ctrl_valid", 1, 0);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        chk("ctrl_sel", int'(vid.ctrl_sel), int'(e[2:1]));
        chk("ctrl_border", int'(vid.ctrl_border), int'(e[0]));
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected control word for pixel p of line j, from the border rules.
  function automatic logic [2:0] model_word(input int p, input int j);
    bit b;
    logic [1:0] s;
    b = (p == 0) || (p == H - 1) || (j == 0) || (j == V - 1);
    if (!sh_en)                  s = 2'd1;
    else if (b && sh_mode == 1)  s = 2'd1;
    else if (b && sh_mode == 2)  s = 2'd2;
    else                         s = 2'd0;
    return {s, b};
  endfunction

  task automatic drive_frame(input bit en, input logic [1:0] mode);
    int p;
    cfg_filter_en       = en;
    cfg_border_mode     = mode;
    vid.per_frame_vsync = 1'b1;
    sh_en   = en;
    sh_mode = mode;
    cyc();
    repeat (2) cyc();
    for (int j = 0; j < n_lines; j++) begin
      vid.per_frame_href = 1'b1;
      p = 0;
      while (p < line_len[j]) begin
        vid.per_frame_clken = ($urandom_range(0, 3) != 0);
        if (cfg_toggle) begin
          cfg_filter_en   = 1'($urandom);
          cfg_border_mode = 2'($urandom);
        end
        if (vid.per_frame_clken) begin
          exp_q.push_back(model_word(p, j));
          p++;
        end
        cyc();
      end
      vid.per_frame_clken = 1'b0;
      vid.per_frame_href  = 1'b0;
      if (line_len[j] != H) exp_line_err = 1'b1;
      if (j == n_lines - 1 && coincide) begin
        vid.per_frame_vsync = 1'b0;
        cyc();
      end else begin
        repeat ($urandom_range(1, 3)) cyc();
      end
    end
    if (!coincide) begin
      vid.per_frame_vsync = 1'b0;
      cyc();
    end
    if (n_lines != V) exp_size_err = 1'b1;
    exp_frames++;
    repeat (4) cyc();
  endtask

  task automatic check_status(input string tag);
    int exp_cnt_hw;
`ifdef MEDIAN_CTRL_STATS_EN
    exp_cnt_hw = exp_frames & 16'hFFFF;
`else
    exp_cnt_hw = 0;
`endif
    @(negedge clk);
    chk({tag, ".line_err"},     int'(line_err), int'(exp_line_err));
    chk({tag, ".size_err"},     int'(size_err), int'(exp_size_err));
    chk({tag, ".frame_cnt"},    int'(frame_cnt), exp_cnt_hw);
    chk({tag, ".frame_done_n"}, done_cnt - done_base, exp_frames);
    chk({tag, ".frame_active"}, int'(frame_active), 0);
    chk({tag, ".pending_exp"},  exp_q.size(), 0);
    #1;
  endtask

  task automatic set_regular(input int nl, input bit co);
    n_lines  = nl;
    coincide = co;
    for (int i = 0; i < 8; i++) line_len[i] = H;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    exp_line_err = 1'b0;
    exp_size_err = 1'b0;
    cyc();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".ctrl_valid"},   int'(vid.ctrl_valid), 0);
    chk({tag, ".ctrl_sel"},     int'(vid.ctrl_sel), 0);
    chk({tag, ".frame_active"}, int'(frame_active), 0);
    chk({tag, ".frame_done"},   int'(frame_done), 0);
    chk({tag, ".line_err"},     int'(line_err), 0);
    chk({tag, ".size_err"},     int'(size_err), 0);
    chk({tag, ".frame_cnt"},    int'(frame_cnt), 0);
    chk({tag, ".state"},        int'(dbg_state), int'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    cfg_filter_en = 1'b0;
    cfg_border_mode = 2'd0;
    err_clr = 1'b0;
    vid.per_frame_vsync = 1'b1;   // a frame is already running at reset
    vid.per_frame_href  = 1'b1;
    vid.per_frame_clken = 1'b1;
    cfg_toggle = 1'b0;
    exp_frames = 0;
    done_base  = 0;

    repeat (3) @(negedge clk);
    check_reset_values("reset");

    // Release mid-frame: the partial frame must be ignored entirely.
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 0; j < 2; j++) begin
      vid.per_frame_href = 1'b1;
      repeat (H) begin
        vid.per_frame_clken = 1'($urandom);
        cyc();
      end
      vid.per_frame_href = 1'b0;
      vid.per_frame_clken = 1'b0;
      repeat (2) cyc();
    end
    vid.per_frame_vsync = 1'b0;
    repeat (5) cyc();
    check_status("skip_partial");

    // Directed frames
    set_regular(V, 1'b0);
    drive_frame(1'b1, 2'd1);  check_status("mode1");
    drive_frame(1'b0, 2'd2);  check_status("filter_off");
    drive_frame(1'b1, 2'd2);  check_status("mode2");
    drive_frame(1'b1, 2'd3);  check_status("mode3");
    drive_frame(1'b1, 2'd0);  check_status("mode0");

    // Short line -> sticky line_err, survives a good frame, cleared by err_clr
    set_regular(V, 1'b0);
    line_len[1] = H - 1;
    drive_frame(1'b1, 2'd1);  check_status("short_line");
    set_regular(V, 1'b0);
    drive_frame(1'b1, 2'd1);  check_status("line_err_sticky");
    pulse_err_clr();          check_status("err_clr1");

    // Line count mismatch with href/vsync fall coincident, then a good one
    set_regular(2, 1'b1);
    drive_frame(1'b1, 2'd2);  check_status("two_lines");
    pulse_err_clr();          check_status("err_clr2");
    set_regular(V, 1'b1);
    drive_frame(1'b1, 2'd2);  check_status("three_lines_coincide");

    // err_clr wins over a set in the same cycle: hold err_clr through a bad frame
    set_regular(2, 1'b1);
    line_len[0] = H + 1;
    err_clr = 1'b1;
    drive_frame(1'b1, 2'd1);
    err_clr = 1'b0;
    exp_line_err = 1'b0;
    exp_size_err = 1'b0;
    check_status("err_clr_priority");

    // Mid-frame configuration changes are ignored
    cfg_toggle = 1'b1;
    set_regular(V, 1'b0);
    drive_frame(1'b1, 2'd1);  check_status("cfg_toggle");

    // Randomized frames
    for (int f = 0; f < 24; f++) begin
      n_lines  = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 4) : V;
      coincide = 1'($urandom);
      for (int i = 0; i < 8; i++)
        line_len[i] = ($urandom_range(0, 5) == 0) ? $urandom_range(H - 2, H + 2) : H;
      drive_frame(1'($urandom), 2'($urandom));
      check_status("random");
      if ($urandom_range(0, 3) == 0) pulse_err_clr();
    end
    cfg_toggle = 1'b0;

    // Asynchronous reset in the middle of an active frame
    vid.per_frame_vsync = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    chk("active_before_reset", int'(frame_active), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    exp_frames = 0;
    exp_line_err = 1'b0;
    exp_size_err = 1'b0;
    done_base = done_cnt;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) cyc();          // vsync still high: frame skipped
    vid.per_frame_vsync = 1'b0;
    repeat (4) cyc();
    check_status("after_async_reset");
    set_regular(V, 1'b0);
    drive_frame(1'b1, 2'd2);  check_status("frame_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
